// File: rtl/word_cache.sv
// word_cache: direct-mapped, write-through, no-write-allocate cache of one-word lines
// between the core memory port and physical memory; rev 1.0
`default_nettype none

module word_cache #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_byte_enable,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata
);

  localparam int LINES = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_be;

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_BITS-1:0] w_fill_idx;
  logic [TAG_W-1:0]    w_fill_tag;
  logic                w_hit;
  logic                w_unused;

  assign w_idx      = mem_address[IDX_BITS+1:2];
  assign w_tag      = mem_address[31:IDX_BITS+2];
  assign w_fill_idx = r_addr[IDX_BITS-1:0];
  assign w_fill_tag = r_addr[29:IDX_BITS];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused   = ^mem_address[1:0];

  // pmem and core outputs come only from state and latched registers
  assign pmem_read        = (r_state == S_FILL);
  assign pmem_write       = (r_state == S_WRITE);
  assign pmem_address     = {r_addr, 2'b00};
  assign pmem_wdata       = r_wdata;
  assign pmem_byte_enable = r_be;
  assign mem_resp         = (r_state == S_RESP);
  assign mem_rdata        = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_write) begin
          w_next = S_WRITE;
        end else if (mem_read) begin
          w_next = w_hit ? S_RESP : S_FILL;
        end
      end
      S_FILL:  if (pmem_resp) w_next = S_RESP;
      S_WRITE: if (pmem_resp) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_write) begin
            r_addr  <= mem_address[31:2];
            r_wdata <= mem_wdata;
            r_be    <= mem_byte_enable;
          end else if (mem_read) begin
            if (w_hit) begin
              r_rdata <= r_data[w_idx];
            end else begin
              r_addr <= mem_address[31:2];
            end
          end
        end
        S_FILL: begin
          if (pmem_resp) begin
            r_rdata             <= pmem_rdata;
            r_valid[w_fill_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array updates depend on r_state, which reset forces to IDLE with all lines invalid
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && mem_write && w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_enable[b]) begin
          r_data[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
    if ((r_state == S_FILL) && pmem_resp) begin
      r_data[w_fill_idx] <= pmem_rdata;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_word_cache.sv
// tb_word_cache: scoreboard bench for word_cache with a latency-programmable pmem model.
`default_nettype none

module tb_word_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = 4'h0;
  logic [31:0] mem_address = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  word_cache #(.IDX_BITS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_byte_enable  (mem_byte_enable),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_resp         (mem_resp),
    .mem_rdata        (mem_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_resp        (pmem_resp),
    .pmem_rdata       (pmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } pmem_t;

  resp_t mq[$];
  pmem_t pq[$];

  int total = 0;
  int bad   = 0;

  int          pmem_lat  = 3;
  logic [31:0] pmem_ret  = 32'h0;
  bit          auto_pmem = 1'b1;
  int          late_req  = 0;
  int          late_ack  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // pmem model: answers after pmem_lat cycles, or emits a stray pulse on request
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (late_req != late_ack) begin
        late_ack++;
        pmem_resp  = 1'b1;
        pmem_rdata = 32'hBAD0_BAD0;
      end else if (auto_pmem && (pmem_read || pmem_write)) begin
        cnt++;
        if (cnt >= pmem_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_ret;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // core-side monitor
  initial begin
    bit    prev_resp;
    bit    prev_pr;
    resp_t e;
    prev_resp = 1'b0;
    prev_pr   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (prev_pr) check32("resp_after_pmem_resp", {31'b0, mem_resp}, 32'd1);
      if (mem_resp) begin
        if (prev_resp) begin
          total++; bad++;
          $display("FAIL resp_consecutive: got mem_resp high two cycles, required one");
        end
        if (mq.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: got mem_resp=1 rdata %h, required no response", mem_rdata);
        end else begin
          e = mq.pop_front();
          if (e.chk) check32("mem_rdata", mem_rdata, e.data);
        end
      end
      prev_resp = mem_resp;
      prev_pr   = pmem_resp && (pmem_read || pmem_write);
    end
  end

  // pmem-side monitor
  initial begin
    bit    prev_req;
    pmem_t e;
    logic [69:0] held;
    prev_req = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if ((pmem_read || pmem_write) && !prev_req) begin
        check32("pmem_exclusive", {31'b0, pmem_read & pmem_write}, 32'd0);
        if (pq.size() == 0) begin
          total++; bad++;
          $display("FAIL pmem_unexpected: got rd=%0b wr=%0b addr %h, required no pmem request",
                   pmem_read, pmem_write, pmem_address);
        end else begin
          e = pq.pop_front();
          check32("pmem_write_flag", {31'b0, pmem_write}, {31'b0, e.wr});
          check32("pmem_read_flag", {31'b0, pmem_read}, {31'b0, ~e.wr});
          check32("pmem_address", pmem_address, e.addr);
          if (e.wr) begin
            check32("pmem_byte_enable", {28'b0, pmem_byte_enable}, {28'b0, e.be});
            check32("pmem_wdata", pmem_wdata, e.wdata);
          end
        end
        held = {pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata};
      end else if ((pmem_read || pmem_write) && prev_req) begin
        if ({pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata} !== held) begin
          total++; bad++;
          $display("FAIL pmem_hold: got addr %h wdata %h, required held addr %h wdata %h",
                   pmem_address, pmem_wdata, held[67:36], held[31:0]);
        end
      end
      prev_req = pmem_read || pmem_write;
    end
  end

  task automatic core_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic exp_pmem, input logic [31:0] pdata,
                          input logic [31:0] exp_rd);
    resp_t r;
    pmem_t p;
    int    cyc;
    r.chk  = ~wr;
    r.data = exp_rd;
    mq.push_back(r);
    if (exp_pmem) begin
      p.wr    = wr;
      p.addr  = {addr[31:2], 2'b00};
      p.be    = be;
      p.wdata = wdata;
      pq.push_back(p);
    end
    pmem_ret = pdata;
    @(negedge clk);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wdata;
    mem_byte_enable = be;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_resp && cyc < 60);
    if (!mem_resp) begin
      total++; bad++;
      $display("FAIL req_timeout: got no mem_resp for addr %h after %0d cycles, required a response", addr, cyc);
    end else if (!exp_pmem) begin
      check32("hit_latency", cyc, 32'd1);
    end
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = 32'hFFFF_FFFF;
    mem_wdata       = 32'h5A5A_5A5A;
    mem_byte_enable = 4'hF;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pmem_t p;
    int    cyc;

    #1;
    check32("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
    check32("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    check32("rst_pmem_write", {31'b0, pmem_write}, 32'd0);
    check32("rst_pmem_address", pmem_address, 32'h0);
    check32("rst_pmem_wdata", pmem_wdata, 32'h0);
    check32("rst_pmem_be", {28'b0, pmem_byte_enable}, 32'h0);
    check32("rst_mem_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // cold miss then hit
    pmem_lat = 3;
    core_req(1, 0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    core_req(1, 0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'h0,         32'hDEAD_BEEF);

    // write-hit merge
    pmem_lat = 1;
    core_req(0, 1, 32'h0000_0040, 32'h1122_3344, 4'b1111, 1, 32'h0, 32'h0);
    core_req(0, 1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0101, 1, 32'h0, 32'h0);
    core_req(1, 0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'h0, 32'h11BB_33DD);

    // write miss does not allocate
    pmem_lat = 2;
    core_req(0, 1, 32'h0000_0080, 32'h5566_7788, 4'b1111, 1, 32'h0, 32'h0);
    core_req(1, 0, 32'h0000_0080, 32'h0, 4'h0, 1, 32'h99AA_BBCC, 32'h99AA_BBCC);
    core_req(1, 0, 32'h0000_0080, 32'h0, 4'h0, 0, 32'h0,         32'h99AA_BBCC);

    // same-index conflict
    core_req(1, 0, 32'h0000_0000, 32'h0, 4'h0, 1, 32'h0000_0A0A, 32'h0000_0A0A);
    core_req(1, 0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'h1234_5678, 32'h1234_5678);
    core_req(1, 0, 32'h0000_0000, 32'h0, 4'h0, 1, 32'h0000_0B0B, 32'h0000_0B0B);

    // write to a different-tag valid line leaves it intact
    core_req(0, 1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b1111, 1, 32'h0, 32'h0);
    core_req(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, 32'h0, 32'h0000_0B0B);

    // low address bits ignored; top index
    core_req(1, 0, 32'h0000_0006, 32'h0, 4'h0, 1, 32'h4444_4444, 32'h4444_4444);
    core_req(1, 0, 32'h0000_0005, 32'h0, 4'h0, 0, 32'h0,         32'h4444_4444);
    core_req(1, 0, 32'h0000_003C, 32'h0, 4'h0, 1, 32'h3C3C_3C3C, 32'h3C3C_3C3C);
    core_req(1, 0, 32'h0000_003C, 32'h0, 4'h0, 0, 32'h0,         32'h3C3C_3C3C);

    // both requests high: write wins
    core_req(1, 1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 1, 32'h0, 32'h0);
    core_req(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, 32'h0, 32'hCAFE_F00D);

    // async reset in the middle of a fill
    auto_pmem = 1'b0;
    p.wr = 1'b0; p.addr = 32'h0000_0100; p.be = 4'h0; p.wdata = 32'h0;
    pq.push_back(p);
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 32'h0000_0100;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!pmem_read && cyc < 20);
    check32("fill_started", {31'b0, pmem_read}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    mem_read = 1'b0;
    #1;
    check32("rst_mid_fill_pmem_read", {31'b0, pmem_read}, 32'd0);
    check32("rst_mid_fill_mem_resp", {31'b0, mem_resp}, 32'd0);
    check32("rst_mid_fill_pmem_address", pmem_address, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    late_req++;
    repeat (4) @(negedge clk);
    auto_pmem = 1'b1;

    core_req(1, 0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
    core_req(1, 0, 32'h0000_003C, 32'h0, 4'h0, 1, 32'h3C3C_0000, 32'h3C3C_0000);
    core_req(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0,         32'h0F0F_0F0F);

    repeat (5) @(negedge clk);
    check32("resp_queue_drained", mq.size(), 32'd0);
    check32("pmem_queue_drained", pq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
